hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for a multiply.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for a divide.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 rsD, rtD  in  5 each  source registers of the D-stage instruction.
REQ-006 TuseRsD, TuseRtD  in  2 each  cycles until operand needed; 3 means not read.
REQ-007 rsE, rtE  in  5 each  source registers of the E-stage instruction.
REQ-008 rtM  in  5  store-data source register of the M-stage instruction.
REQ-009 RegWriteE/M/W  in  1 each  stage instruction writes the register file.
REQ-010 WriteRegE/M/W  in  5 each  destination register per stage.
REQ-011 TnewE, TnewM  in  2 each  cycles until stage result is ready.
REQ-012 MdStartE  in  1  mult/div instruction in E this cycle.
REQ-013 MdIsDivE  in  1  with MdStartE: 1 = divide, 0 = multiply.
REQ-014 MdUseD  in  1  D instruction uses HI/LO or the mult/div unit.
REQ-015 StallF, StallD  out  1 each  hold PC and F/D register.
REQ-016 FlushE  out  1  clear D/E register; inserts a bubble.
REQ-017 ForwardRsD, ForwardRtD, ForwardRsE, ForwardRtE  out  2 each  operand select.
REQ-018 ForwardRtM  out  1  M-stage store data from W.
REQ-019 MdBusy  out  1  mult/div unit occupied.

Function
REQ-020 A source matches a stage when the register is nonzero, equal to that stage's WriteReg, and RegWrite is 1.
REQ-021 The controller SHALL stall when a D source matches E with Tuse < TnewE, or matches M with Tuse < TnewM.
REQ-022 The controller SHALL stall when MdUseD = 1 and (MdBusy = 1 or MdStartE = 1).
REQ-023 During a stall, StallF = StallD = FlushE = 1 in the same cycle; otherwise all three are 0. This path is combinational.
REQ-024 Forward encoding: 0 = register file, 1 = E result, 2 = M result, 3 = W result.
REQ-025 D forward priority: E if matched and TnewE = 0, else M if matched and TnewM = 0, else W if matched, else 0.
REQ-026 E forward priority: M if matched and TnewM = 0, else W if matched, else 0. No E code is used.
REQ-027 ForwardRtM = 1 when rtM matches W.
REQ-028 The mult/div FSM has states IDLE and BUSY and an internal down-counter cnt of 4 bits or more.
REQ-029 In IDLE with MdStartE = 1, the FSM SHALL load cnt with DIV_CYCLES or MULT_CYCLES per MdIsDivE and enter BUSY next cycle.
REQ-030 In BUSY, cnt decrements each cycle; when cnt = 1, the FSM returns to IDLE next cycle. BUSY therefore lasts exactly N cycles.
REQ-031 MdBusy SHALL be 1 exactly when state = BUSY (registered).
REQ-032 MdStartE in BUSY is ignored; the simulation assertion "md start while busy" SHALL fire.
REQ-033 Parameters below 1 are illegal; an elaboration-time check SHALL flag them.

Reset
REQ-034 On reset: state = IDLE, cnt = 0, MdBusy = 0, and the counter (if present) = 0. Reset takes priority over MdStartE.
REQ-035 Reset during BUSY SHALL abort the operation with no residual stall on the next cycle.

Configuration
REQ-036 With STALL_COUNT_EN defined, output StallCount (out, 32 bits) SHALL increment once per stall cycle and wrap from 0xFFFFFFFF to 0.
REQ-037 Without STALL_COUNT_EN, neither the port nor the counter exists, and all other behaviour is unchanged.

Structure
REQ-038 Package hazard_pkg SHALL hold the forward-select constants (FWD_RF, FWD_E, FWD_M, FWD_W), the FSM state enum, and TUSE_NONE = 3.
REQ-039 The mult/div FSM and counter SHALL be sub-module md_busy_fsm. Stall and forward logic stays in hazard_ctrl.

Verification
REQ-040 lw $1 in E (TnewE = 2), D reads $1 with TuseRsD = 0 -> stall; next cycle TnewM = 1 -> stall; then ForwardRsD = 2.
REQ-041 addu writes $3, TnewE = 0, D reads $3 with Tuse = 1 -> no stall, ForwardRsD = 1. Same case with $0 -> ForwardRsD = 0.
REQ-042 MdStartE = 1, MdIsDivE = 1 -> MdBusy high for exactly 10 cycles. mfhi in D throughout -> stalled 11 cycles, including the start cycle.
REQ-043 Reset asserted on the 3rd BUSY cycle of a mult -> MdBusy = 0 and no stall on the next cycle.
REQ-044 E and M both write $5 with TnewE = TnewM = 0 -> ForwardRsD = 1 (E wins). rtM = $5 matching W -> ForwardRtM = 1.
REQ-045 STALL_COUNT_EN with the counter preloaded to 0xFFFFFFFF by force, then one stall cycle -> StallCount = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants, types and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

  // A source hits a stage only for a nonzero register the stage actually writes.
  function automatic logic reg_hit(input logic [4:0] src, input logic rw, input logic [4:0] wr);
    return (src != 5'd0) && rw && (src == wr);
  endfunction

  function automatic int cnt_width(input int max_cycles);
    int w;
    w = $clog2(max_cycles + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals seen by the hazard controller.
interface hazard_ctrl_if;
  logic [4:0] rsD, rtD, rsE, rtE, rtM;
  logic [1:0] TuseRsD, TuseRtD, TnewE, TnewM;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       MdStartE, MdIsDivE, MdUseD;
  logic       StallF, StallD, FlushE;
  logic [1:0] ForwardRsD, ForwardRtD, ForwardRsE, ForwardRtE;
  logic       ForwardRtM, MdBusy;

  modport slave (
    input  rsD, rtD, rsE, rtE, rtM, TuseRsD, TuseRtD, TnewE, TnewM,
           RegWriteE, RegWriteM, RegWriteW, WriteRegE, WriteRegM, WriteRegW,
           MdStartE, MdIsDivE, MdUseD,
    output StallF, StallD, FlushE, ForwardRsD, ForwardRtD, ForwardRsE, ForwardRtE,
           ForwardRtM, MdBusy
  );

  modport master (
    output rsD, rtD, rsE, rtE, rtM, TuseRsD, TuseRtD, TnewE, TnewM,
           RegWriteE, RegWriteM, RegWriteW, WriteRegE, WriteRegM, WriteRegW,
           MdStartE, MdIsDivE, MdUseD,
    input  StallF, StallD, FlushE, ForwardRsD, ForwardRtD, ForwardRsE, ForwardRtE,
           ForwardRtM, MdBusy
  );
endinterface

// File: rtl/md_busy_fsm.sv
// Mult/div occupancy tracker: BUSY for exactly MULT_CYCLES or DIV_CYCLES after a start.
module md_busy_fsm
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CNT_W = cnt_width((DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES);

  if (MULT_CYCLES < 1) begin : g_bad_mult
    $error("MULT_CYCLES must be at least 1");
  end
  if (DIV_CYCLES < 1) begin : g_bad_div
    $error("DIV_CYCLES must be at least 1");
  end

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: if (start) begin
        cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        state_d = MD_BUSY;
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = (state_q == MD_BUSY);

  a_md_start_busy: assert property (@(posedge clk) disable iff (reset)
    !(start && state_q == MD_BUSY)) else $error("md start while busy");

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush and operand-forwarding control for a 5-stage pipeline.
// Optional STALL_COUNT_EN adds a free-running 32-bit stall-cycle counter output.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
`ifdef STALL_COUNT_EN
  output logic [31:0]   StallCount,
`endif
  hazard_ctrl_if.slave  hz
);

  logic md_busy;
  logic rs_e, rt_e, rs_m, rt_m, rs_w, rt_w;
  logic stall;

  md_busy_fsm #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (hz.MdStartE),
    .is_div (hz.MdIsDivE),
    .busy   (md_busy)
  );

  always_comb begin
    rs_e = reg_hit(hz.rsD, hz.RegWriteE, hz.WriteRegE);
    rt_e = reg_hit(hz.rtD, hz.RegWriteE, hz.WriteRegE);
    rs_m = reg_hit(hz.rsD, hz.RegWriteM, hz.WriteRegM);
    rt_m = reg_hit(hz.rtD, hz.RegWriteM, hz.WriteRegM);
    rs_w = reg_hit(hz.rsD, hz.RegWriteW, hz.WriteRegW);
    rt_w = reg_hit(hz.rtD, hz.RegWriteW, hz.WriteRegW);

    // TUSE_NONE is never below a 2-bit Tnew, so unread sources cannot stall.
    stall = (rs_e && hz.TuseRsD < hz.TnewE) || (rt_e && hz.TuseRtD < hz.TnewE) ||
            (rs_m && hz.TuseRsD < hz.TnewM) || (rt_m && hz.TuseRtD < hz.TnewM) ||
            (hz.MdUseD && (md_busy || hz.MdStartE));

    hz.ForwardRsD = FWD_RF;
    if      (rs_e && hz.TnewE == 2'd0) hz.ForwardRsD = FWD_E;
    else if (rs_m && hz.TnewM == 2'd0) hz.ForwardRsD = FWD_M;
    else if (rs_w)                     hz.ForwardRsD = FWD_W;

    hz.ForwardRtD = FWD_RF;
    if      (rt_e && hz.TnewE == 2'd0) hz.ForwardRtD = FWD_E;
    else if (rt_m && hz.TnewM == 2'd0) hz.ForwardRtD = FWD_M;
    else if (rt_w)                     hz.ForwardRtD = FWD_W;

    hz.ForwardRsE = FWD_RF;
    if      (reg_hit(hz.rsE, hz.RegWriteM, hz.WriteRegM) && hz.TnewM == 2'd0) hz.ForwardRsE = FWD_M;
    else if (reg_hit(hz.rsE, hz.RegWriteW, hz.WriteRegW))                     hz.ForwardRsE = FWD_W;

    hz.ForwardRtE = FWD_RF;
    if      (reg_hit(hz.rtE, hz.RegWriteM, hz.WriteRegM) && hz.TnewM == 2'd0) hz.ForwardRtE = FWD_M;
    else if (reg_hit(hz.rtE, hz.RegWriteW, hz.WriteRegW))                     hz.ForwardRtE = FWD_W;

    hz.ForwardRtM = reg_hit(hz.rtM, hz.RegWriteW, hz.WriteRegW);
  end

  assign hz.StallF = stall;
  assign hz.StallD = stall;
  assign hz.FlushE = stall;
  assign hz.MdBusy = md_busy;

`ifdef STALL_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, forwarding, mult/div busy window, reset abort.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

`ifdef STALL_COUNT_EN
  logic [31:0] stall_count;
  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .StallCount(stall_count), .hz(hz));
`else
  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .hz(hz));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0; hz.rtM = 0;
    hz.TuseRsD = 2'd3; hz.TuseRtD = 2'd3; hz.TnewE = 0; hz.TnewM = 0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
    hz.MdStartE = 0; hz.MdIsDivE = 0; hz.MdUseD = 0;
  endtask

  task automatic stall_chk(input string tag, input logic exp);
    chk({tag, ".StallF"}, {31'd0, hz.StallF}, {31'd0, exp});
    chk({tag, ".StallD"}, {31'd0, hz.StallD}, {31'd0, exp});
    chk({tag, ".FlushE"}, {31'd0, hz.FlushE}, {31'd0, exp});
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.MdBusy", {31'd0, hz.MdBusy}, 32'd0);
    stall_chk("rst", 1'b0);
`ifdef STALL_COUNT_EN
    chk("rst.StallCount", stall_count, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;

    // load-use: lw $1 in E, then in M, then result ready in M
    @(negedge clk);
    hz.rsD = 5'd1; hz.TuseRsD = 2'd0;
    hz.RegWriteE = 1; hz.WriteRegE = 5'd1; hz.TnewE = 2'd2; #1;
    stall_chk("lw_E", 1'b1);
    @(negedge clk);
    hz.RegWriteE = 0; hz.RegWriteM = 1; hz.WriteRegM = 5'd1; hz.TnewM = 2'd1; #1;
    stall_chk("lw_M", 1'b1);
    @(negedge clk);
    hz.TnewM = 2'd0; #1;
    stall_chk("lw_rdy", 1'b0);
    chk("lw_rdy.FwdRsD", {30'd0, hz.ForwardRsD}, 32'd2);

    // addu $3 in E, D reads it with Tuse 1
    @(negedge clk); idle_inputs();
    hz.rsD = 5'd3; hz.TuseRsD = 2'd1;
    hz.RegWriteE = 1; hz.WriteRegE = 5'd3; hz.TnewE = 2'd0; #1;
    stall_chk("addu", 1'b0);
    chk("addu.FwdRsD", {30'd0, hz.ForwardRsD}, 32'd1);
    @(negedge clk);
    hz.rsD = 5'd0; hz.WriteRegE = 5'd0; #1;
    chk("zero.FwdRsD", {30'd0, hz.ForwardRsD}, 32'd0);

    // rt source vs M with Tnew 2; then the same source marked unread
    @(negedge clk); idle_inputs();
    hz.rtD = 5'd7; hz.TuseRtD = 2'd1;
    hz.RegWriteM = 1; hz.WriteRegM = 5'd7; hz.TnewM = 2'd2; #1;
    stall_chk("rtM_hz", 1'b1);
    @(negedge clk); hz.TuseRtD = 2'd3; #1;
    stall_chk("rt_unused", 1'b0);

    // E and M both write $5; W also writes $5
    @(negedge clk); idle_inputs();
    hz.rsD = 5'd5; hz.rtD = 5'd5; hz.TuseRsD = 2'd0; hz.TuseRtD = 2'd0;
    hz.RegWriteE = 1; hz.WriteRegE = 5'd5; hz.TnewE = 2'd0;
    hz.RegWriteM = 1; hz.WriteRegM = 5'd5; hz.TnewM = 2'd0;
    hz.RegWriteW = 1; hz.WriteRegW = 5'd5;
    hz.rsE = 5'd5; hz.rtE = 5'd5; hz.rtM = 5'd5; #1;
    chk("prio.FwdRsD", {30'd0, hz.ForwardRsD}, 32'd1);
    chk("prio.FwdRtD", {30'd0, hz.ForwardRtD}, 32'd1);
    chk("prio.FwdRsE", {30'd0, hz.ForwardRsE}, 32'd2);
    chk("prio.FwdRtM", {31'd0, hz.ForwardRtM}, 32'd1);
    stall_chk("prio", 1'b0);
    @(negedge clk);
    hz.RegWriteE = 0; hz.TnewM = 2'd1; hz.TuseRsD = 2'd1; hz.TuseRtD = 2'd3; #1;
    chk("wfwd.FwdRsE", {30'd0, hz.ForwardRsE}, 32'd3);
    chk("wfwd.FwdRtE", {30'd0, hz.ForwardRtE}, 32'd3);
    chk("wfwd.FwdRsD", {30'd0, hz.ForwardRsD}, 32'd3);
    stall_chk("wfwd", 1'b0);
    @(negedge clk); hz.rtM = 5'd6; #1;
    chk("nohit.FwdRtM", {31'd0, hz.ForwardRtM}, 32'd0);

    // divide with mfhi waiting in D
    @(negedge clk); idle_inputs();
    hz.MdUseD = 1; hz.MdStartE = 1; hz.MdIsDivE = 1; #1;
    stall_chk("div_start", 1'b1);
    chk("div_start.MdBusy", {31'd0, hz.MdBusy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); hz.MdStartE = 0; hz.MdIsDivE = 0; #1;
      chk($sformatf("div_busy%0d", i), {31'd0, hz.MdBusy}, 32'd1);
      chk($sformatf("div_stall%0d", i), {31'd0, hz.StallF}, 32'd1);
    end
    @(negedge clk); #1;
    chk("div_done.MdBusy", {31'd0, hz.MdBusy}, 32'd0);
    stall_chk("div_done", 1'b0);

    // multiply length, bounded wait
    @(negedge clk); idle_inputs(); hz.MdStartE = 1; #1;
    @(negedge clk); hz.MdStartE = 0; #1;
    n = 0;
    while (hz.MdBusy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    chk("mult_len", n, 32'd5);

    // reset on the 3rd busy cycle of a multiply
    @(negedge clk); idle_inputs(); hz.MdStartE = 1; #1;
    @(negedge clk); hz.MdStartE = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("abort.busy3", {31'd0, hz.MdBusy}, 32'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; hz.MdUseD = 1; #1;
    chk("abort.MdBusy", {31'd0, hz.MdBusy}, 32'd0);
    stall_chk("abort", 1'b0);

`ifdef STALL_COUNT_EN
    @(negedge clk); idle_inputs();
    force dut.stall_count_q = 32'hFFFF_FFFF;
    #1 release dut.stall_count_q;
    hz.MdUseD = 1; hz.MdStartE = 1;
    @(negedge clk); idle_inputs(); #1;
    chk("cnt_wrap", stall_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
